dru_store_unit: RTL

//   Write-back path for the data register unit: the store-side counterpart of the DRU load path.

---
 rtl/dru_store_if.sv | 34 +++
 rtl/dru_store_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/dru_store_if.sv
// Store-side bus bundle for the data register unit: store request channel
// plus the 32-bit write-beat channel toward memory.
interface dru_store_if #(
  parameter int DATA_W = 64,
  parameter int MEM_W  = 32,
  parameter int ADDR_W = 16
);
  // Request handshake: a store transfers on a rising clock edge where
  // st_valid and st_ready are both high; st_ready is high only while the
  // unit is idle, and st_valid outside that window is ignored, not queued.
  // Write beats: mem_wr_en holds with mem_addr/mem_data_out stable until a
  // cycle with mem_ack high closes the beat at that cycle's edge.
  logic [DATA_W-1:0] st_data;
  logic [ADDR_W-1:0] st_addr;
  logic              st_valid;
  logic              st_ready;
  logic [MEM_W-1:0]  mem_data_out;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic              mem_ack;
  logic              str_mux_sel;
  logic              st_done;
  logic              st_err;

  modport master (
    output st_data, st_addr, st_valid, mem_ack,
    input  st_ready, mem_data_out, mem_addr, mem_wr_en, str_mux_sel, st_done, st_err
  );

  modport slave (
    input  st_data, st_addr, st_valid, mem_ack,
    output st_ready, mem_data_out, mem_addr, mem_wr_en, str_mux_sel, st_done, st_err
  );
endinterface

// File: rtl/dru_store_unit.sv
// DRU write-back path: captures a 64-bit word and writes it to the 32-bit
// memory bus as two acked beats (upper half first), with a per-beat watchdog.
module dru_store_unit #(
  parameter int DATA_W  = 64,
  parameter int MEM_W   = 32,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic       sys_clk,
  input  logic       clear_data_regs,
  dru_store_if.slave bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_HI = 2'd1,
    WR_LO = 2'd2
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_ON = (TIMEOUT != 0);

  state_t            state;
  logic [DATA_W-1:0] hold;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  wd_cnt;
  logic [MEM_W-1:0]  data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wr_en_r;
  logic              mux_r;
  logic              done_r;
  logic              err_r;

  // Expiry: counter sits at WD_LAST in the last allowed cycle of a beat.
  logic wd_expire;
  assign wd_expire = WD_ON && (wd_cnt == WD_LAST);

  always_ff @(posedge sys_clk) begin
    if (clear_data_regs) begin
      state   <= IDLE;
      hold    <= '0;
      base    <= '0;
      wd_cnt  <= '0;
      data_r  <= '0;
      addr_r  <= '0;
      wr_en_r <= 1'b0;
      mux_r   <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.st_valid) begin
            state   <= WR_HI;
            hold    <= bus.st_data;
            base    <= bus.st_addr;
            wd_cnt  <= '0;
            wr_en_r <= 1'b1;
            mux_r   <= 1'b0;
            data_r  <= bus.st_data[DATA_W-1:MEM_W];
            addr_r  <= bus.st_addr;
          end
        end
        WR_HI: begin
          if (bus.mem_ack) begin
            state  <= WR_LO;
            wd_cnt <= '0;
            mux_r  <= 1'b1;
            data_r <= hold[MEM_W-1:0];
            addr_r <= base + ADDR_W'(1);
          end else if (wd_expire) begin
            state   <= IDLE;
            wr_en_r <= 1'b0;
            mux_r   <= 1'b0;
            data_r  <= '0;
            err_r   <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        WR_LO: begin
          // Ack beats expiry when both land in the same cycle.
          if (bus.mem_ack || wd_expire) begin
            state   <= IDLE;
            wr_en_r <= 1'b0;
            mux_r   <= 1'b0;
            data_r  <= '0;
            done_r  <= bus.mem_ack;
            err_r   <= !bus.mem_ack;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          wr_en_r <= 1'b0;
          mux_r   <= 1'b0;
          data_r  <= '0;
        end
      endcase
    end
  end

  assign bus.st_ready     = (state == IDLE);
  assign bus.mem_data_out = data_r;
  assign bus.mem_addr     = addr_r;
  assign bus.mem_wr_en    = wr_en_r;
  assign bus.str_mux_sel  = mux_r;
  assign bus.st_done      = done_r;
  assign bus.st_err       = err_r;
  assign dbg_state        = state;

endmodule
